// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: stall/flush/next-PC control,
// exception drain FSM, EPC capture and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned PC_W         = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [PC_W-1:0] id_pc,
  input  logic            id_jump,
  input  logic            id_exception,
  input  logic            ex_memread,
  input  logic [4:0]      ex_rt,
  input  logic            mem_branch_taken,
  input  logic            mem_busy,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic [1:0]      pc_sel,
  output logic [PC_W-1:0] epc,
  output logic            exc_active,
  output logic [15:0]     stall_cnt
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STALL_W = 16;

  localparam logic [1:0] SEL_PC4    = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JUMP   = 2'd2;
  localparam logic [1:0] SEL_VECTOR = 2'd3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    VECTOR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  drain_q, drain_d;
  logic [PC_W-1:0]   epc_q, epc_d;
  logic [STALL_W-1:0] stall_q;
  logic              load_use;

  assign load_use = ex_memread && (ex_rt != 5'd0) && id_valid &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  // Next-state and control outputs; reset forces a fully flushed, frozen front end.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_sel      = SEL_PC4;
    state_d     = state_q;
    drain_d     = drain_q;
    epc_d       = epc_q;

    if (!rst_n) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_busy) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
          end else if (mem_branch_taken) begin
            pc_sel      = SEL_BRANCH;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (id_exception && id_valid) begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            epc_d      = id_pc;
            drain_d    = CNT_W'(DRAIN_CYCLES - 1);
            state_d    = DRAIN;
          end else if (id_jump && id_valid) begin
            pc_sel     = SEL_JUMP;
            ifid_flush = 1'b1;
          end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
          end
        end

        DRAIN: begin
          if (mem_busy) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (mem_branch_taken) begin
            // Older branch resolved taken: the excepting instruction was on the wrong path.
            pc_sel      = SEL_BRANCH;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            drain_d     = '0;
            state_d     = RUN;
          end else begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (drain_q == '0) begin
              state_d = VECTOR;
            end else begin
              drain_d = drain_q - CNT_W'(1);
            end
          end
        end

        VECTOR: begin
          pc_sel     = SEL_VECTOR;
          ifid_flush = 1'b1;
          if (mem_busy) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
          end else begin
            state_d = RUN;
          end
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State, drain counter, EPC and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= '0;
      epc_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      epc_q   <= epc_d;
      if (!pc_we && (stall_q != '1)) begin
        stall_q <= stall_q + STALL_W'(1);
      end
    end
  end

  assign epc        = epc_q;
  assign exc_active = (state_q != RUN);
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: stimulus pushes expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic [31:0] id_pc = '0;
  logic        id_jump = 1'b0;
  logic        id_exception = 1'b0;
  logic        ex_memread = 1'b0;
  logic [4:0]  ex_rt = '0;
  logic        mem_branch_taken = 1'b0;
  logic        mem_busy = 1'b0;
  logic        pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  pc_sel;
  logic [31:0] epc;
  logic        exc_active;
  logic [15:0] stall_cnt;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(2), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_pc(id_pc), .id_jump(id_jump), .id_exception(id_exception),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .mem_busy(mem_busy), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .pc_sel(pc_sel), .epc(epc),
    .exc_active(exc_active), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ctrl = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pc_sel[1:0], exc_active}
  localparam logic [7:0] C_RST   = 8'b0_0_1_1_1_00_0;
  localparam logic [7:0] C_RUN   = 8'b1_1_0_0_0_00_0;
  localparam logic [7:0] C_LU    = 8'b0_0_0_1_0_00_0;
  localparam logic [7:0] C_BR    = 8'b1_1_1_1_1_01_0;
  localparam logic [7:0] C_EXC   = 8'b0_1_1_1_0_00_0;
  localparam logic [7:0] C_JMP   = 8'b1_1_1_0_0_10_0;
  localparam logic [7:0] C_BUSY  = 8'b0_0_0_0_0_00_0;
  localparam logic [7:0] C_DRN   = 8'b0_1_1_1_0_00_1;
  localparam logic [7:0] C_DRNB  = 8'b0_0_1_1_0_00_1;
  localparam logic [7:0] C_BRDRN = 8'b1_1_1_1_1_01_1;
  localparam logic [7:0] C_VEC   = 8'b1_1_1_0_0_11_1;
  localparam logic [7:0] C_VECB  = 8'b0_0_1_0_0_11_1;

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] epc;
    logic [15:0] stall;
    int          tag;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_epc = '0;
  logic [15:0] exp_stall = '0;

  // One cycle of stimulus; expected registered values reflect edges before this cycle.
  task automatic cyc(input logic rst, input logic busy, input logic br, input logic exc,
                     input logic jmp, input logic idv, input logic [4:0] rs,
                     input logic [4:0] rt, input logic memrd, input logic [4:0] xrt,
                     input logic [31:0] pc, input logic [7:0] ctrl, input int tag,
                     input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; mem_busy = busy; mem_branch_taken = br; id_exception = exc;
    id_jump = jmp; id_valid = idv; id_rs = rs; id_rt = rt; ex_memread = memrd;
    ex_rt = xrt; id_pc = pc;
    if (!rst) begin
      exp_stall = '0;
      exp_epc   = '0;
    end
    if (chk) begin
      e.ctrl = ctrl; e.epc = exp_epc; e.stall = exp_stall; e.tag = tag;
      sb.push_back(e);
    end
    if (rst && !ctrl[7] && (exp_stall != 16'hFFFF)) exp_stall = exp_stall + 16'd1;
  endtask

  task automatic idle(input logic [7:0] ctrl, input int tag);
    cyc(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 32'h0, ctrl, tag, 1);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [7:0]  act;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        act = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pc_sel, exc_active};
        checks++;
        if (act !== e.ctrl) begin
          failures++;
          $display("FAIL ctrl tag=%0d got=%b exp=%b", e.tag, act, e.ctrl);
        end
        checks++;
        if (epc !== e.epc) begin
          failures++;
          $display("FAIL epc tag=%0d got=%h exp=%h", e.tag, epc, e.epc);
        end
        checks++;
        if (stall_cnt !== e.stall) begin
          failures++;
          $display("FAIL stall_cnt tag=%0d got=%h exp=%h", e.tag, stall_cnt, e.stall);
        end
      end
    end
  end

  initial begin : stim
    // Reset state
    cyc(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 32'h0, C_RST, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 32'h0, C_RST, 2, 1);
    idle(C_RUN, 3);
    // Load-use on rs, then clears; ex_rt = 0 never stalls; rt match; invalid ID
    cyc(1, 0, 0, 0, 0, 1, 5'd5, 5'd0, 1, 5'd5, 32'h0, C_LU, 4, 1);
    idle(C_RUN, 5);
    cyc(1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 32'h0, C_RUN, 6, 1);
    cyc(1, 0, 0, 0, 0, 1, 5'd1, 5'd7, 1, 5'd7, 32'h0, C_LU, 7, 1);
    cyc(1, 0, 0, 0, 0, 0, 5'd7, 5'd7, 1, 5'd7, 32'h0, C_RUN, 8, 1);
    // Branch and exception together: branch wins, no drain, epc untouched
    cyc(1, 0, 1, 1, 0, 1, 5'd0, 5'd0, 0, 5'd0, 32'h0000_1234, C_BR, 9, 1);
    idle(C_RUN, 10);
    // mem_busy in RUN freezes everything, even with an exception pending
    cyc(1, 1, 1, 1, 0, 1, 5'd5, 5'd0, 1, 5'd5, 32'h0000_5678, C_BUSY, 11, 1);
    idle(C_RUN, 12);
    // Exception: 1 RUN + 2 DRAIN + 1 VECTOR
    cyc(1, 0, 0, 1, 0, 1, 5'd0, 5'd0, 0, 5'd0, 32'h0040_0010, C_EXC, 13, 1);
    exp_epc = 32'h0040_0010;
    idle(C_DRN, 14);
    idle(C_DRN, 15);
    idle(C_VEC, 16);
    idle(C_RUN, 17);
    // Exception with mem_busy held 4 cycles at the start of DRAIN
    cyc(1, 0, 0, 1, 0, 1, 5'd0, 5'd0, 0, 5'd0, 32'h0040_0020, C_EXC, 18, 1);
    exp_epc = 32'h0040_0020;
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 32'h0, C_DRNB, 19 + i, 1);
    idle(C_DRN, 23);
    idle(C_DRN, 24);
    idle(C_VEC, 25);
    idle(C_RUN, 26);
    // Taken branch during DRAIN cancels the exception
    cyc(1, 0, 0, 1, 0, 1, 5'd0, 5'd0, 0, 5'd0, 32'h0040_0030, C_EXC, 27, 1);
    exp_epc = 32'h0040_0030;
    idle(C_DRN, 28);
    cyc(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 32'h0, C_BRDRN, 29, 1);
    idle(C_RUN, 30);
    // mem_busy during VECTOR holds the vector
    cyc(1, 0, 0, 1, 0, 1, 5'd0, 5'd0, 0, 5'd0, 32'h0040_0040, C_EXC, 31, 1);
    exp_epc = 32'h0040_0040;
    idle(C_DRN, 32);
    idle(C_DRN, 33);
    cyc(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 32'h0, C_VECB, 34, 1);
    idle(C_VEC, 35);
    idle(C_RUN, 36);
    // Jump, then load-use on the following instruction
    cyc(1, 0, 0, 0, 1, 1, 5'd0, 5'd0, 0, 5'd0, 32'h0, C_JMP, 37, 1);
    cyc(1, 0, 0, 0, 0, 1, 5'd3, 5'd0, 1, 5'd3, 32'h0, C_LU, 38, 1);
    idle(C_RUN, 39);
    // Reset asserted mid-drain takes effect before the next rising edge
    cyc(1, 0, 0, 1, 0, 1, 5'd0, 5'd0, 0, 5'd0, 32'h0040_0050, C_EXC, 40, 1);
    exp_epc = 32'h0040_0050;
    idle(C_DRN, 41);
    cyc(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 32'h0, C_RST, 42, 1);
    idle(C_RUN, 43);
    // Saturation: 65534 unchecked stall cycles, then 3 more and an idle
    for (int i = 0; i < 65534; i++)
      cyc(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 32'h0, C_BUSY, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 32'h0, C_BUSY, 44 + i, 1);
    idle(C_RUN, 47);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencer for the 5-stage MIPS core. It takes the decoded control bundle and the register indices of the ID, EX and MEM stages. It generates the PC/IF-ID write enables, per-stage flushes and the next-PC select for load-use stalls, taken branches, jumps, data-memory wait states and decode exceptions. It also owns the exception drain state machine, the EPC register and a saturating stall-cycle counter.

## Interface
- DRAIN_CYCLES, 2: cycles the front end is held empty after an exception before vectoring (legal 1..15).
- PC_W, 32: PC / EPC width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
- id_pc  in  PC_W  PC of the instruction in ID.
- id_jump  in  1  jump decoded in ID.
- id_exception  in  1  decode exception from the control decoder.
- ex_memread  in  1  MemRead of the instruction in EX.
- ex_rt  in  5  destination of the load in EX.
- mem_branch_taken  in  1  Branch && condition true, evaluated in MEM.
- mem_busy  in  1  data memory is not ready and MEM must hold.
- pc_we, ifid_we  out  1 each  PC and IF/ID write enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  insert a bubble into that register on the next edge.
- pc_sel  out  2  selects the next PC: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = exception vector.
- epc  out  PC_W  PC of the last excepting instruction.
- exc_active  out  1  high in DRAIN and VECTOR.
- stall_cnt  out  16  saturating count of cycles with pc_we = 0.

## Operation
- States: RUN, DRAIN, VECTOR. The down-counter drain_cnt is 4 bits wide.
- Default output set: pc_we = 1, ifid_we = 1, all flushes 0, pc_sel = 0.
- Load-use hazard: ex_memread && ex_rt != 0 && id_valid && (ex_rt == id_rs || ex_rt == id_rt).
- In RUN, conditions are resolved in this priority order:
  1. mem_busy: pc_we = 0, ifid_we = 0, no flushes. The whole pipe freezes and no state changes.
  2. mem_branch_taken: pc_sel = 1, and ifid_flush, idex_flush and exmem_flush are all 1. A simultaneous exception or jump is discarded because it is on the wrong path.
  3. id_exception && id_valid: ifid_flush = 1 and idex_flush = 1, pc_we = 0. The block captures epc <= id_pc, loads drain_cnt <= DRAIN_CYCLES-1 and moves to DRAIN.
  4. id_jump && id_valid: pc_sel = 2, ifid_flush = 1.
  5. Load-use hazard: pc_we = 0, ifid_we = 0, idex_flush = 1. This is a single bubble that re-evaluates every cycle.
- DRAIN:
  - Outputs: pc_we = 0, ifid_flush = 1, idex_flush = 1. EX and MEM keep retiring older instructions.
  - mem_busy freezes drain_cnt and forces ifid_we = 0.
  - mem_branch_taken applies the branch output set of RUN, cancels the exception and returns to RUN. epc keeps the captured value.
  - drain_cnt == 0 moves the block to VECTOR. Otherwise drain_cnt decrements.
- VECTOR:
  - Outputs: pc_sel = 3, pc_we = 1, ifid_flush = 1. Next state is RUN.
  - mem_busy holds the block in VECTOR with pc_we = 0.
- stall_cnt increments on every clock edge where pc_we = 0 and rst_n = 1. It saturates at 16'hFFFF and does not wrap.

## Timing
- All control outputs are combinational from the inputs and the current state. The PC and pipeline registers consume them on the next rising edge.
- epc, state, drain_cnt and stall_cnt are registered.
- While rst_n = 0:
  - State = RUN, drain_cnt = 0, epc = 0, stall_cnt = 0, exc_active = 0.
  - pc_we = 0, ifid_we = 0, all flushes = 1, pc_sel = 0.
- Reset deassertion takes effect at the first edge after rst_n rises. Reset asserted mid-drain aborts the drain immediately and leaves epc = 0.
- Load-use costs exactly 1 stall cycle. A taken branch costs 3 flushed slots. A jump costs 1.
- Exception-to-vector latency: the exception cycle in RUN, then DRAIN_CYCLES cycles in DRAIN, then 1 cycle in VECTOR, with no mem_busy. The vector PC is loaded at the end of VECTOR.
- exc_active rises on the edge that enters DRAIN and falls on the edge that leaves VECTOR.

## Test plan
- Load-use: lw with ex_rt = 5 in EX, id_rs = 5 in ID -> 1 cycle with pc_we = 0, ifid_we = 0, idex_flush = 1; stall_cnt = 1. Repeat with ex_rt = 0 -> no stall.
- Branch plus exception in the same cycle: mem_branch_taken = 1, id_exception = 1 -> pc_sel = 1, all three flushes = 1, state stays RUN, epc unchanged.
- Exception with DRAIN_CYCLES = 2 and id_pc = 0x00400010 -> epc = 0x00400010 after the first edge, 2 DRAIN cycles, 1 VECTOR cycle with pc_sel = 3, then RUN; stall_cnt = 3.
- mem_busy held 4 cycles during DRAIN -> drain_cnt frozen, total exception latency 1 + 2 + 4 + 1 cycles, no flush of EX/MEM.
- Jump followed by load-use on the next instruction -> pc_sel = 2 with ifid_flush for 1 cycle, then a 1-cycle stall, in order.
- Reset asserted in DRAIN -> state = RUN, epc = 0, stall_cnt = 0 asynchronously. Force stall_cnt to 16'hFFFE with 3 further stall cycles -> it holds at 16'hFFFF.
